// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, segment table and width helper for the seven-segment scanner
package seg_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] ANODE_OFF = 8'hFF;
  // active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/hex7_decode.sv
// hex7_decode: hex nibble to active-low seven-segment pattern
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  always_comb seg_n = ~HEX_SEG[nibble];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with prescaler, frame-synchronous
// shadow loading, anti-ghosting guard and PWM brightness
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int GUARD_CYCLES = 16,
  parameter int DUTY_BITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [DUTY_BITS-1:0]    brightness,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_done
);
  localparam int IW = clog2(NUM_DIGITS);
  localparam int PW = clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GUARD = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [DUTY_BITS-1:0] pwm;
  logic [NUM_DIGITS-1:0][3:0] act_dig, pend_dig;
  logic [NUM_DIGITS-1:0] act_dp, act_blank, pend_dp, pend_blank;
  logic pend_valid;
  logic tick, wrap, show;
  logic [NUM_DIGITS-1:0] sel_n;
  logic [6:0] dec_n;
  always_comb begin
    tick  = en && (pre == PRE_LAST);
    wrap  = tick && (idx == IDX_LAST);
    show  = en && (pre >= GUARD) && (pwm < brightness) && !act_blank[idx];
    sel_n = ~(NUM_DIGITS'(1) << idx);
  end
  hex7_decode u_dec (
    .nibble(act_dig[idx]),
    .seg_n (dec_n)
  );
  // pending set is swapped into the active set only at the frame wrap so a frame is never mixed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre        <= '0;
      idx        <= '0;
      pwm        <= '0;
      act_dig    <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      pend_valid <= 1'b0;
      anode_n    <= ANODE_OFF[NUM_DIGITS-1:0];
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (en) begin
        pre <= tick ? '0 : pre + 1'b1;
        pwm <= pwm + 1'b1;
        if (tick) idx <= wrap ? '0 : idx + 1'b1;
      end
      if (wrap && pend_valid) begin
        act_dig   <= pend_dig;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (load) begin
        pend_dig   <= digits_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
      anode_n    <= show ? sel_n : ANODE_OFF[NUM_DIGITS-1:0];
      seg_n      <= dec_n;
      dp_n       <= ~act_dp[idx];
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized scoreboard bench for seg_scan_ctrl against a cycle-count reference model
module tb_seg_scan_ctrl;
  localparam int N = 4, CD = 8, G = 2, DB = 2, FRAME = N * CD;
  logic clk = 1'b0;
  logic rst, en = 1'b0, load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0, blank_in = '0;
  logic [1:0] brightness = '0;
  logic [3:0] anode_n;
  logic [6:0] seg_n;
  logic dp_n, frame_done;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       chk;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  logic [6:0] hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int t;
  logic [15:0] a_dig, p_dig;
  logic [3:0] a_dp, a_bl, p_dp, p_bl;
  logic pv;

  seg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(CD), .GUARD_CYCLES(G), .DUTY_BITS(DB)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .brightness(brightness), .anode_n(anode_n), .seg_n(seg_n),
    .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    t = 0; a_dig = '0; a_dp = '0; a_bl = '1; p_dig = '0; p_dp = '0; p_bl = '1; pv = 1'b0;
  endtask

  // position in the scan follows directly from the number of enabled cycles since reset
  task automatic cyc();
    exp_t e;
    int pre, idx, pwm;
    logic [3:0] nib;
    if (rst) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0; e.chk = 1'b1;
      model_reset();
    end else begin
      pre = t % CD;
      idx = (t / CD) % N;
      pwm = t % (1 << DB);
      nib = a_dig[idx*4 +: 4];
      e.an  = (en && pre >= G && pwm < int'(brightness) && !a_bl[idx]) ? ~(4'b0001 << idx) : 4'hF;
      e.seg = ~hex[nib];
      e.dp  = ~a_dp[idx];
      e.fd  = en && (t % FRAME == FRAME - 1);
      e.chk = e.an != 4'hF;
      if (e.fd && pv) begin a_dig = p_dig; a_dp = p_dp; a_bl = p_bl; pv = 1'b0; end
      if (load) begin p_dig = digits_in; p_dp = dp_in; p_bl = blank_in; pv = 1'b1; end
      if (en) t++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits_in = d; dp_in = p; blank_in = b; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic chk_dark();
    chk("rst_anode", anode_n, 4'hF);
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_dp", dp_n, 1);
    chk("rst_fd", frame_done, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("anode_n", anode_n, e.an);
        chk("frame_done", frame_done, e.fd);
        if (e.chk) begin
          chk("seg_n", seg_n, e.seg);
          chk("dp_n", dp_n, e.dp);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    #1;
    chk_dark();
    model_reset();
    @(negedge clk);
    repeat (3) cyc();
    rst = 1'b0;
    en = 1'b1; brightness = 2'd3;
    do_load(16'h4321, 4'h0, 4'h0);
    repeat (3 * FRAME) cyc();
    repeat (13) cyc();
    do_load(16'hFFFF, 4'h0, 4'h0);
    repeat (2 * FRAME) cyc();
    brightness = 2'd1;
    repeat (FRAME) cyc();
    brightness = 2'd0;
    repeat (FRAME) cyc();
    brightness = 2'd3;
    do_load(16'h9A5C, 4'b0010, 4'b0101);
    repeat (2 * FRAME) cyc();
    do_load(16'h7E0B, 4'b1001, 4'h0);
    repeat (5) cyc();
    en = 1'b0;
    repeat (20) cyc();
    en = 1'b1;
    repeat (FRAME) cyc();
    for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) cyc();
    do_load(16'h8D62, 4'b0100, 4'h0);
    repeat (2 * FRAME) cyc();
    for (int i = 0; i < 1500; i++) begin
      en = $urandom_range(0, 15) != 0;
      if ($urandom_range(0, 40) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 12) == 0) begin
        digits_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom & $urandom); load = 1'b1;
      end
      cyc();
      load = 1'b0;
    end
    en = 1'b1; brightness = 2'd3;
    do_load(16'h0123, 4'h0, 4'h0);
    repeat (FRAME + 11) cyc();
    #2 rst = 1'b1;
    #1;
    chk_dark();
    repeat (2) cyc();
    rst = 1'b0;
    repeat (10) cyc();
    do_load(16'hBEEF, 4'b1000, 4'h0);
    repeat (2 * FRAME) cyc();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
